instruction_fetch: RTL and testbench
====================================

# instruction_fetch

- Fetch stage that sits directly upstream of the single-cycle datapath.
- Holds the program counter and requests 32-bit words from an instruction memory with variable latency.
- Presents one instruction at a time to the datapath through a valid/ready handshake.
- Computes the next PC from the datapath's `Zero` and `out32` outputs and the control unit's `Branch` and `Jump` flags.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value after reset. Bits [1:0] must be 0.
- `TIMEOUT_CYCLES`, default 16: cycles without a memory response before a retry. Used only with `IFETCH_TIMEOUT_EN`.
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `imem_req`, out, 1: fetch request. Held high until `imem_valid`.
- `imem_addr`, out, 32: word address, equal to `pc`. Bits [1:0] are always 0.
- `imem_rdata`, in, 32: instruction word. Sampled only when `imem_valid & imem_req`.
- `imem_valid`, in, 1: memory response strobe. May arrive in the same cycle as the request or any later cycle.
- `instruction`, out, 32: registered instruction driven to the datapath.
- `instr_valid`, out, 1: `instruction` holds a fetched word.
- `instr_ready`, in, 1: datapath consumes `instruction` this cycle.
- `Branch`, in, 1: conditional branch flag from control. Sampled on the handshake cycle.
- `Jump`, in, 1: J-type jump flag. Sampled on the handshake cycle.
- `Zero`, in, 1: datapath ALU zero flag. Sampled on the handshake cycle.
- `out32`, in, 32: datapath sign-extended immediate. Sampled on the handshake cycle.
- `pc`, out, 32: address of the current instruction.
- `pc_plus4`, out, 32: `pc + 4`, combinational.
- `fetch_err`, out, 1: sticky timeout flag. Tied to 0 without `IFETCH_TIMEOUT_EN`.

## Operation
- States:
  - S_IDLE: reset state. Always moves to S_REQ on the next cycle.
  - S_REQ: `imem_req=1`. On `imem_valid`, latch `imem_rdata` into `instruction` and go to S_ISSUE.
  - S_ISSUE: `instr_valid=1`. Hold `instruction` and `pc` stable until `instr_ready`.
- Handshake: on `instr_valid & instr_ready`:
  - `pc` takes the next-PC value and the state returns to S_REQ.
  - `instr_valid` drops in the following cycle.
- Next-PC priority:
  - `Jump`: `{pc_plus4[31:28], instruction[25:0], 2'b00}`.
  - Otherwise `Branch & Zero`: `pc_plus4 + (out32 << 2)`.
  - Otherwise: `pc_plus4`.
  - `Jump` wins when both `Jump` and `Branch` are set.
- Arithmetic is modulo 2^32. Adding 4 to 32'hFFFF_FFFC gives 0. A negative branch offset wraps the same way.
- `imem_valid` outside S_REQ is ignored, including a stale response arriving after reset.
- `instr_ready` outside S_ISSUE is ignored and does not change `pc`.
- No delay slot: the instruction after a taken branch is never fetched.

## Timing
- Reset values (applied at the first edge with `rst=1`):
  - state S_IDLE, `pc=RESET_PC`.
  - `instruction=0`, `instr_valid=0`, `imem_req=0`, `fetch_err=0`.
  - Timeout counter 0.
- First request: `imem_req` rises in the cycle after `rst` falls.
- Minimum throughput, with `imem_valid` in the request cycle and `instr_ready` held high: one instruction per 2 cycles.
  - Cycle N: S_REQ.
  - Cycle N+1: S_ISSUE with the handshake.
  - Cycle N+2: S_REQ at the new PC.
- Memory latency L ≥ 0 cycles adds L cycles per instruction.
- Consumer stall: `instruction`, `pc` and `instr_valid` hold indefinitely.
- Reset mid-operation, in any state: the next edge forces the reset values. An in-flight handshake or response is discarded.

## Configuration
- Macro `IFETCH_TIMEOUT_EN`.
- When defined:
  - A counter increments on each S_REQ cycle without `imem_valid`.
  - When it reaches `TIMEOUT_CYCLES`: set `fetch_err`, clear the counter, deassert `imem_req` for exactly one cycle, then re-request the same `pc`.
  - `fetch_err` clears only on `rst`.
- When undefined:
  - S_REQ waits forever.
  - No counter logic is built and `fetch_err` is constant 0.

## Structure
- `mips_pkg` holds:
  - The state enum `ifetch_state_t` (S_IDLE, S_REQ, S_ISSUE).
  - Constant `PC_STEP = 32'd4`.
  - Field-position constants for the jump target (`JTARGET_MSB = 25`).
- One combinational sub-module, `pc_next`.
  - Inputs: `pc_plus4`, `instruction`, `out32`, `Branch`, `Jump`, `Zero`.
  - Output: the next PC.
  - Verified standalone as well.

## Test plan
- Reset, zero-latency memory, `instr_ready=1`, no branches:
  - `imem_addr` sequence 0, 4, 8, 12 on every other cycle.
  - `instr_valid` alternates 0/1.
- Memory latency 3 at `pc=8`:
  - `imem_req` high for 4 cycles, `instr_valid` low throughout.
  - `instruction` equals `imem_rdata` one cycle after `imem_valid`.
- Taken branch at `pc=32'h40` with `Branch=1`, `Zero=1`, `out32=32'hFFFF_FFFE`:
  - Next `imem_addr = 32'h3C`.
  - With `Zero=0` instead: `32'h44`.
- `Jump=1` and `Branch=1` together, `pc=32'h1000_0000`, `instruction=32'h0800_0010`: next `pc = 32'h1000_0040`.
- `instr_ready` held low for 5 cycles: `instruction` and `pc` stable.
- `rst` pulsed during S_ISSUE: `pc=RESET_PC` and `instr_valid=0` after the edge.
- With `IFETCH_TIMEOUT_EN` and `TIMEOUT_CYCLES=16`, no response:
  - `fetch_err` rises after 16 cycles.
  - `imem_req` low for 1 cycle, then re-requested at the same address.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the instruction fetch stage.
package mips_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_ISSUE = 2'd2
  } ifetch_state_t;

  localparam logic [31:0] PC_STEP = 32'd4;

  // J-type target field and the PC region bits that are kept across a jump
  localparam int unsigned JTARGET_MSB = 25;
  localparam int unsigned JREGION_LSB = 28;

endpackage

// File: rtl/pc_next.sv
// Next-PC selection: jump, taken branch or sequential, in that priority.
module pc_next
  import mips_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [31:0] instruction,
  input  logic [31:0] out32,
  input  logic        Branch,
  input  logic        Jump,
  input  logic        Zero,
  output logic [31:0] next_pc
);

  logic [31:0] jump_tgt;
  logic [31:0] branch_tgt;
  logic        unused_opcode;

  assign jump_tgt      = {pc_plus4[31:JREGION_LSB], instruction[JTARGET_MSB:0], 2'b00};
  assign branch_tgt    = pc_plus4 + (out32 << 2);
  assign unused_opcode = ^instruction[31:JTARGET_MSB+1];

  // Jump beats a taken branch when both flags are set
  always_comb begin
    next_pc = pc_plus4;
    if (Jump) begin
      next_pc = jump_tgt;
    end else if (Branch && Zero) begin
      next_pc = branch_tgt;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: holds the PC, requests words from a variable-latency memory and
// hands one instruction at a time to the datapath over a valid/ready handshake.
// Optional request timeout/retry is built when IFETCH_TIMEOUT_EN is defined.
module instruction_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] instruction,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        Branch,
  input  logic        Jump,
  input  logic        Zero,
  input  logic [31:0] out32,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_err
);

  ifetch_state_t state_q;
  logic [31:0]   pc_q;
  logic [31:0]   pc_d;
  logic [31:0]   instr_q;
  logic          req_gap;
  logic          rsp_accept;

  // Outputs are decoded straight from registered state
  assign imem_req    = (state_q == S_REQ) && !req_gap;
  assign rsp_accept  = imem_req && imem_valid;
  assign instr_valid = (state_q == S_ISSUE);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + PC_STEP;
  assign instruction = instr_q;

  pc_next u_pc_next (
    .pc_plus4    (pc_plus4),
    .instruction (instr_q),
    .out32       (out32),
    .Branch      (Branch),
    .Jump        (Jump),
    .Zero        (Zero),
    .next_pc     (pc_d)
  );

  // Fetch FSM: request, latch the response, hold it until the datapath takes it
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= {RESET_PC[31:2], 2'b00};
      instr_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: state_q <= S_REQ;
        S_REQ: begin
          if (rsp_accept) begin
            instr_q <= imem_rdata;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (instr_ready) begin
            pc_q    <= pc_d;
            state_q <= S_REQ;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef IFETCH_TIMEOUT_EN
  logic [31:0] tmo_cnt_q;
  logic        gap_q;
  logic        fetch_err_q;

  assign req_gap   = gap_q;
  assign fetch_err = fetch_err_q;

  // Count unanswered request cycles; on expiry drop the request for one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q   <= '0;
      gap_q       <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      gap_q <= 1'b0;
      if (imem_req && !imem_valid) begin
        if (tmo_cnt_q == TIMEOUT_CYCLES - 1) begin
          tmo_cnt_q   <= '0;
          gap_q       <= 1'b1;
          fetch_err_q <= 1'b1;
        end else begin
          tmo_cnt_q <= tmo_cnt_q + 32'd1;
        end
      end else begin
        tmo_cnt_q <= '0;
      end
    end
  end
`else
  logic unused_timeout;

  assign req_gap        = 1'b0;
  assign fetch_err      = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: expected (pc, instruction) pairs are
// queued as stimulus is issued and checked by a monitor at each handshake.
module tb_instruction_fetch;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        instr_ready;
  logic        Branch;
  logic        Jump;
  logic        Zero;
  logic [31:0] out32;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_err;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_err    = 0;

  // Memory model controls
  logic [31:0] lat_addr = 32'hFFFF_FFF0;
  logic        stray    = 1'b0;
  logic        mute     = 1'b0;
  int          wcnt     = 0;
  int          lat_now;

  instruction_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_valid  (imem_valid),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .Branch      (Branch),
    .Jump        (Jump),
    .Zero        (Zero),
    .out32       (out32),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .fetch_err   (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (a == 32'h0000_000C || a == 32'h1000_0000) return 32'h0800_0010;
    return {16'hC0DE, a[15:0]};
  endfunction

  // Memory responder: latency 3 at lat_addr, 0 elsewhere; stray forces a bogus strobe
  always @(posedge clk) begin
    #1;
    lat_now = (imem_addr == lat_addr) ? 3 : 0;
    if (stray) begin
      imem_valid = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      wcnt       = 0;
    end else if (imem_req && !mute) begin
      if (wcnt >= lat_now) begin
        imem_valid = 1'b1;
        imem_rdata = word_at(imem_addr);
        wcnt       = 0;
      end else begin
        imem_valid = 1'b0;
        wcnt++;
      end
    end else begin
      imem_valid = 1'b0;
      imem_rdata = 32'h0;
      wcnt       = 0;
    end
  end

  // Monitor: every accepted instruction must match the head of the scoreboard
  always @(negedge clk) begin
    if (!rst && instr_valid && instr_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL sb_unexpected: handshake at pc %h with nothing expected", pc);
      end else begin
        mon_e = sb_q.pop_front();
        n_checks++;
        if (pc !== mon_e.pc) begin
          n_err++;
          $display("FAIL sb_pc: got %h expected %h", pc, mon_e.pc);
        end
        n_checks++;
        if (instruction !== mon_e.ins) begin
          n_err++;
          $display("FAIL sb_instr at pc %h: got %h expected %h", mon_e.pc, instruction, mon_e.ins);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [31:0] epc, input logic [31:0] eins);
    exp_t e;
    e.pc  = epc;
    e.ins = eins;
    sb_q.push_back(e);
  endtask

  // Queue one expectation, drive control flags for its handshake, wait for it
  task automatic issue_one(input logic [31:0] epc, input logic [31:0] eins, input logic br,
                           input logic jp, input logic z, input logic [31:0] off);
    int n;
    push(epc, eins);
    Branch      = br;
    Jump        = jp;
    Zero        = z;
    out32       = off;
    instr_ready = 1'b1;
    n = 0;
    while (!instr_valid && n < 20) begin
      cyc();
      n++;
    end
    if (!instr_valid) begin
      n_checks++;
      n_err++;
      $display("FAIL issue_wait: instr_valid %b for pc %h, required 1", instr_valid, epc);
    end else begin
      cyc();
    end
    Branch = 1'b0;
    Jump   = 1'b0;
    Zero   = 1'b0;
    out32  = 32'h0;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!instr_valid && n < 20) begin
      cyc();
      n++;
    end
    chk(name, {31'b0, instr_valid}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    instr_ready = 1'b0;
    Branch      = 1'b0;
    Jump        = 1'b0;
    Zero        = 1'b0;
    out32       = 32'h0;
    imem_valid  = 1'b0;
    imem_rdata  = 32'h0;

    // Reset values
    cyc();
    chk("rst_pc", pc, 32'h0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_instr", instruction, 32'h0);
    chk("rst_err", {31'b0, fetch_err}, 32'd0);

    // Zero latency, consumer always ready, sequential flow
    push(32'h0, 32'hC0DE_0000);
    push(32'h4, 32'hC0DE_0004);
    push(32'h8, 32'hC0DE_0008);
    push(32'hC, 32'h0800_0010);
    instr_ready = 1'b1;
    rst         = 1'b0;
    cyc();
    for (int k = 0; k < 8; k++) begin
      chk("seq_valid", {31'b0, instr_valid}, k % 2);
      if (k % 2 == 0) begin
        chk("seq_req", {31'b0, imem_req}, 32'd1);
        chk("seq_addr", imem_addr, k * 2);
      end
      cyc();
    end

    // Latency 3 at pc 8
    rst = 1'b1;
    cyc();
    lat_addr = 32'h8;
    push(32'h0, 32'hC0DE_0000);
    push(32'h4, 32'hC0DE_0004);
    push(32'h8, 32'hC0DE_0008);
    rst = 1'b0;
    cyc();
    for (int k = 0; k < 4; k++) cyc();
    for (int j = 0; j < 4; j++) begin
      chk("lat_req", {31'b0, imem_req}, 32'd1);
      chk("lat_valid", {31'b0, instr_valid}, 32'd0);
      chk("lat_addr", imem_addr, 32'h8);
      cyc();
    end
    chk("lat_issue", {31'b0, instr_valid}, 32'd1);
    chk("lat_instr", instruction, 32'hC0DE_0008);
    cyc();
    lat_addr = 32'hFFFF_FFF0;

    // Jump, taken / not-taken branches, jump-over-branch priority, wraparound
    issue_one(32'h0000_000C, 32'h0800_0010, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("jmp_addr", imem_addr, 32'h0000_0040);
    issue_one(32'h0000_0040, 32'hC0DE_0040, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE);
    chk("br_back_addr", imem_addr, 32'h0000_003C);
    issue_one(32'h0000_003C, 32'hC0DE_003C, 1'b1, 1'b0, 1'b1, 32'h0);
    chk("br_zero_off_addr", imem_addr, 32'h0000_0040);
    issue_one(32'h0000_0040, 32'hC0DE_0040, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE);
    chk("br_not_taken_addr", imem_addr, 32'h0000_0044);
    issue_one(32'h0000_0044, 32'hC0DE_0044, 1'b1, 1'b0, 1'b1, 32'h03FF_FFEE);
    chk("br_far_addr", imem_addr, 32'h1000_0000);
    issue_one(32'h1000_0000, 32'h0800_0010, 1'b1, 1'b1, 1'b1, 32'h5);
    chk("jmp_prio_addr", imem_addr, 32'h1000_0040);
    issue_one(32'h1000_0040, 32'hC0DE_0040, 1'b1, 1'b0, 1'b1, 32'h3BFF_FFEE);
    chk("br_top_addr", imem_addr, 32'hFFFF_FFFC);
    chk("wrap_plus4", pc_plus4, 32'h0);
    issue_one(32'hFFFF_FFFC, 32'hC0DE_FFFC, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("wrap_addr", imem_addr, 32'h0);

    // Consumer stall for 5 cycles with a stray memory strobe and live flags
    instr_ready = 1'b0;
    wait_valid("stall_wait");
    stray  = 1'b1;
    Branch = 1'b1;
    Zero   = 1'b1;
    out32  = 32'h7;
    for (int k = 0; k < 5; k++) begin
      chk("stall_valid", {31'b0, instr_valid}, 32'd1);
      chk("stall_pc", pc, 32'h0);
      chk("stall_instr", instruction, 32'hC0DE_0000);
      cyc();
    end
    stray  = 1'b0;
    Branch = 1'b0;
    Zero   = 1'b0;
    out32  = 32'h0;
    push(32'h0, 32'hC0DE_0000);
    instr_ready = 1'b1;
    cyc();
    chk("stall_next_addr", imem_addr, 32'h4);

    // Reset during S_ISSUE with a pending handshake and a stale response
    instr_ready = 1'b0;
    wait_valid("rst_issue_wait");
    rst         = 1'b1;
    instr_ready = 1'b1;
    stray       = 1'b1;
    cyc();
    chk("mid_rst_pc", pc, 32'h0);
    chk("mid_rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("mid_rst_req", {31'b0, imem_req}, 32'd0);
    chk("mid_rst_instr", instruction, 32'h0);
    rst         = 1'b0;
    stray       = 1'b0;
    instr_ready = 1'b0;
    mute        = 1'b1;
    cyc();
    chk("stale_instr", instruction, 32'h0);
    chk("stale_req", {31'b0, imem_req}, 32'd1);
    chk("stale_addr", imem_addr, 32'h0);

    // No memory response
`ifdef IFETCH_TIMEOUT_EN
    for (int k = 1; k < 16; k++) begin
      cyc();
      chk("tmo_req", {31'b0, imem_req}, 32'd1);
      chk("tmo_err_low", {31'b0, fetch_err}, 32'd0);
    end
    cyc();
    chk("tmo_err_set", {31'b0, fetch_err}, 32'd1);
    chk("tmo_gap", {31'b0, imem_req}, 32'd0);
    cyc();
    chk("tmo_rereq", {31'b0, imem_req}, 32'd1);
    chk("tmo_readdr", imem_addr, 32'h0);
    chk("tmo_err_sticky", {31'b0, fetch_err}, 32'd1);
`else
    for (int k = 0; k < 20; k++) begin
      cyc();
      chk("wait_req", {31'b0, imem_req}, 32'd1);
      chk("wait_err", {31'b0, fetch_err}, 32'd0);
    end
`endif
    mute = 1'b0;

    chk("sb_empty", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
